// File: rtl/comparador_serial_derizq_ctrl.sv
// -----------------------------------------------------------------------------
// comparador_serial_derizq_ctrl
//
// Bit-serial unsigned comparator. It answers "A <= B ?" by walking one
// comparison cell over the operand bits, LSB first, one bit per clock. At each
// bit where the operands differ, the decision is overwritten by B's bit.
// Because of this, the most significant differing bit has the final say. If
// every bit matches, the initial "equal so far" value of 1 stands.
//
// Handshake: a start pulse accepted in IDLE captures A/B. Then N RUN cycles
// follow, one per bit, and then a single DONE cycle.
//
// Parameters
//   N       operand width in bits (N >= 1)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   request, sampled only in IDLE
//   A, B    in   operands [N-1:0], captured on the accept edge
//   busy    out  high while in RUN or DONE
//   done    out  one-cycle pulse; Zout is valid from this cycle on
//   Zout    out  last result: 1 if A <= B, 0 if A > B; held until next done
//   igual   out  last result: 1 if A == B (only with COMPARADOR_SERIAL_IGUAL_EN)
//
// Configuration macro
//   COMPARADOR_SERIAL_IGUAL_EN  adds the igual output and its equality tracker
// -----------------------------------------------------------------------------
module comparador_serial_derizq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         Zout
`ifdef COMPARADOR_SERIAL_IGUAL_EN
  ,
  output logic         igual
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // The encoding keeps RUN and DONE on separate flop bits.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [CW-1:0] r_cnt;
  logic          r_z;
  logic          r_zout;
  logic          r_done;

  logic          w_a;
  logic          w_b;
  logic          w_z_next;
  logic          w_last;

  // This is the single comparison cell. A differing bit decides in favour of
  // B's bit. A matching bit passes the lower-order decision through unchanged.
  assign w_a      = r_sa[0];
  assign w_b      = r_sb[0];
  assign w_z_next = (w_a != w_b) ? w_b : r_z;
  assign w_last   = (r_cnt == LAST_BIT);

  // NOTE: All state is updated with non-blocking assignments. Every register
  // then samples pre-edge values, so the cell, the shifters and the result
  // register see a consistent snapshot. The operand shift registers and the
  // cell state are also cleared on reset. This leaves no X in the datapath
  // before the first accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_z     <= 1'b0;
      r_zout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= A;
            r_sb    <= B;
            r_cnt   <= '0;
            r_z     <= 1'b1;  // equal so far, so A <= B holds
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_z  <= w_z_next;
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          if (w_last) begin
            // The MSB step has just been evaluated, so publish its result.
            // The counter stays put, so it never wraps.
            r_zout  <= w_z_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign Zout = r_zout;

`ifdef COMPARADOR_SERIAL_IGUAL_EN
  logic r_eq;
  logic r_igual;

  // The equality tracker starts true and is knocked down by any differing bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eq    <= 1'b0;
      r_igual <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_eq <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_a != w_b) begin
            r_eq <= 1'b0;
          end
          if (w_last) begin
            r_igual <= r_eq & (w_a == w_b);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign igual = r_igual;
`endif

endmodule
